// File: rtl/ucaspian_pkg.sv
// Shared constants and types for the uCaspian synapse stage.
package ucaspian_pkg;

    localparam int SYN_IDX_W = 12;
    localparam int NEURON_W  = 8;
    localparam int WEIGHT_W  = 8;
    localparam int SYN_DEPTH = 4096;

    typedef struct packed {
        logic [NEURON_W-1:0] target;
        logic [WEIGHT_W-1:0] weight;
    } syn_entry_t;

    typedef enum logic [1:0] {
        SYN_IDLE,
        SYN_RUN,
        SYN_CLEAR
    } syn_state_t;

endpackage

// File: rtl/dp_ram_16x4096.sv
// Synapse table: one write port, one read port with registered output.
// A same-address read and write in one cycle returns the old entry.
module dp_ram_16x4096
    import ucaspian_pkg::*;
(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [SYN_IDX_W-1:0] wr_addr,
    input  syn_entry_t           wr_data,
    input  logic                 rd_en,
    input  logic [SYN_IDX_W-1:0] rd_addr,
    output syn_entry_t           rd_data
);

    syn_entry_t mem [SYN_DEPTH];
    syn_entry_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ucaspian_synapse.sv
// Walks an inclusive synapse index range, looks each index up in the synapse
// table and emits (neuron, weight) events. Optional: UCASPIAN_SYN_ZERO_SKIP_EN.
module ucaspian_synapse
    import ucaspian_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_act,
    input  logic                 clear_config,
    output logic                 clear_done,
    input  logic [SYN_IDX_W-1:0] config_addr,
    input  logic [7:0]           config_value,
    input  logic [2:0]           config_byte,
    input  logic                 config_enable,
    input  logic                 next_step,
    output logic                 step_done,
    input  logic [SYN_IDX_W-1:0] syn_start,
    input  logic [SYN_IDX_W-1:0] syn_end,
    input  logic                 syn_vld,
    output logic                 syn_rdy,
    output logic [NEURON_W-1:0]  dend_addr,
    output logic [WEIGHT_W-1:0]  dend_charge,
    output logic                 dend_vld,
    input  logic                 dend_rdy
);

    syn_state_t           state_q, state_d;
    logic [SYN_IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [SYN_IDX_W-1:0] end_idx_q, end_idx_d;
    logic [SYN_IDX_W-1:0] clr_addr_q, clr_addr_d;
    logic                 clr_fin_q, clr_fin_d;
    syn_entry_t           stage_q, stage_d;
    logic                 rd_pend_q, rd_pend_d;
    syn_entry_t           fifo_q [2];
    syn_entry_t           fifo_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 clear_done_q, clear_done_d;
    logic                 step_done_q, step_done_d;

    logic                 flush, pop, push, keep, credit, rd_issue;
    logic                 ram_we;
    logic [SYN_IDX_W-1:0] ram_waddr;
    syn_entry_t           ram_wdata, ram_rdata, head;
    logic                 unused_next_step;

    assign unused_next_step = next_step;

    dp_ram_16x4096 u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_en   (rd_issue),
        .rd_addr (cur_idx_q),
        .rd_data (ram_rdata)
    );

    assign flush   = clear_config || clear_act;
    assign dend_vld = (cnt_q != 2'd0);
    assign pop     = dend_vld && dend_rdy;
    // Credit counts the slot freed by this cycle's pop so a steady stream
    // sustains one read per cycle.
    assign credit  = (({1'b0, cnt_q} - {2'b0, pop} + {2'b0, rd_pend_q}) < 3'd2);
    assign syn_rdy = ~reset && (state_q == SYN_IDLE) && ~clear_act && ~clear_config
                     && enable && (cnt_q == 2'd0) && ~rd_pend_q;

`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
    assign keep = (ram_rdata.weight != '0);
`else
    assign keep = 1'b1;
`endif
    assign push = rd_pend_q && keep;

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        end_idx_d    = end_idx_q;
        clr_addr_d   = '0;
        clr_fin_d    = 1'b0;
        clear_done_d = 1'b0;
        rd_issue     = 1'b0;
        stage_d      = stage_q;
        ram_we       = 1'b0;
        ram_waddr    = config_addr;
        ram_wdata.target = stage_q.target;
        ram_wdata.weight = config_value;

        if (clear_config) begin
            state_d = SYN_CLEAR;
            if (state_q == SYN_CLEAR) begin
                clr_fin_d    = clr_fin_q || (clr_addr_q == '1);
                clr_addr_d   = clr_addr_q + SYN_IDX_W'(1);
                clear_done_d = clr_fin_d;
                ram_we       = ~clr_fin_q;
                ram_waddr    = clr_addr_q;
                ram_wdata    = '0;
            end
        end else if (state_q == SYN_CLEAR || clear_act) begin
            state_d      = SYN_IDLE;
            clear_done_d = clear_act;
        end else begin
            case (state_q)
                SYN_IDLE: begin
                    if (syn_vld && syn_rdy) begin
                        cur_idx_d = syn_start;
                        end_idx_d = syn_end;
                        state_d   = SYN_RUN;
                    end
                end
                SYN_RUN: begin
                    if (enable && credit) begin
                        rd_issue = 1'b1;
                        if (cur_idx_q == end_idx_q) begin
                            state_d = SYN_IDLE;
                        end else begin
                            cur_idx_d = cur_idx_q + SYN_IDX_W'(1);
                        end
                    end
                end
                default: state_d = SYN_IDLE;
            endcase
        end

        if (!clear_config && state_q != SYN_CLEAR && config_enable) begin
            case (config_byte)
                3'd1: stage_d = '0;
                3'd2: stage_d.target = config_value;
                3'd3: begin
                    stage_d.weight = config_value;
                    ram_we         = 1'b1;
                end
                default: ;
            endcase
        end
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_pend_d = 1'b0;
        if (!flush) begin
            rd_pend_d = rd_issue;
            if (push) begin
                fifo_d[wr_ptr_q] = ram_rdata;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end else begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = '0;
        end
        step_done_d = (state_q == SYN_IDLE) && (cnt_q == 2'd0) && ~rd_pend_q && ~syn_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYN_IDLE;
            cur_idx_q    <= '0;
            end_idx_q    <= '0;
            clr_addr_q   <= '0;
            clr_fin_q    <= 1'b0;
            stage_q      <= '0;
            rd_pend_q    <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            clear_done_q <= 1'b0;
            step_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            end_idx_q    <= end_idx_d;
            clr_addr_q   <= clr_addr_d;
            clr_fin_q    <= clr_fin_d;
            stage_q      <= stage_d;
            rd_pend_q    <= rd_pend_d;
            fifo_q[0]    <= fifo_d[0];
            fifo_q[1]    <= fifo_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            clear_done_q <= clear_done_d;
            step_done_q  <= step_done_d;
        end
    end

    assign head        = fifo_q[rd_ptr_q];
    assign dend_addr   = dend_vld ? head.target : '0;
    assign dend_charge = dend_vld ? head.weight : '0;
    assign clear_done  = clear_done_q;
    assign step_done   = step_done_q;

endmodule

// File: tb/tb_ucaspian_synapse.sv
// Directed bench for ucaspian_synapse: a shadow synapse table turns each
// accepted range into an expected event queue checked against dend_* every cycle.
module tb_ucaspian_synapse;
    import ucaspian_pkg::*;

`ifdef UCASPIAN_SYN_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, clear_act, clear_config, clear_done;
    logic [11:0] config_addr;
    logic [7:0]  config_value;
    logic [2:0]  config_byte;
    logic        config_enable, next_step, step_done;
    logic [11:0] syn_start, syn_end;
    logic        syn_vld, syn_rdy;
    logic [7:0]  dend_addr, dend_charge;
    logic        dend_vld, dend_rdy;

    ucaspian_synapse dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_act(clear_act),
        .clear_config(clear_config), .clear_done(clear_done),
        .config_addr(config_addr), .config_value(config_value),
        .config_byte(config_byte), .config_enable(config_enable),
        .next_step(next_step), .step_done(step_done),
        .syn_start(syn_start), .syn_end(syn_end), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
        .dend_addr(dend_addr), .dend_charge(dend_charge),
        .dend_vld(dend_vld), .dend_rdy(dend_rdy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] a; logic [7:0] c; } ev_t;

    int   checks = 0;
    int   failures = 0;
    int   ev_cnt = 0;
    int   rdy_mode = 1;
    logic compare_en = 1'b0;
    logic [15:0] model_mem [4096];
    ev_t  exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected events for range s..e (inclusive, wrapping mod 4096).
    task automatic model_range(input int s, input int e);
        int i;
        i = s;
        for (int k = 0; k < 4096; k++) begin
            if (!SKIP || model_mem[i][7:0] != 8'd0)
                exp_q.push_back({model_mem[i][15:8], model_mem[i][7:0]});
            if (i == e) break;
            i = (i + 1) % 4096;
        end
    endtask

    task automatic cfg(input int addr, input logic [7:0] n, input logic [7:0] w);
        @(posedge clk); #1;
        config_enable = 1'b1; config_addr = addr[11:0];
        config_byte = 3'd2; config_value = n;
        @(posedge clk); #1;
        config_byte = 3'd3; config_value = w;
        @(posedge clk); #1;
        config_enable = 1'b0; config_byte = 3'd0;
        model_mem[addr] = {n, w};
    endtask

    task automatic send_range(input int s, input int e);
        int n;
        n = 0;
        @(posedge clk); #1;
        syn_start = s[11:0]; syn_end = e[11:0]; syn_vld = 1'b1;
        @(negedge clk);
        while (!syn_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("handshake", 32'(syn_rdy), 32'd1);
        if (syn_rdy) model_range(s, e);
        @(posedge clk); #1;
        syn_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !step_done) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size() == 0 && step_done), 32'd1);
    endtask

    initial begin
        dend_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       dend_rdy = 1'b0;
                1:       dend_rdy = 1'b1;
                default: dend_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Per-cycle event check; a transfer happens on the next edge when rdy is high.
    initial begin
        forever begin
            @(negedge clk);
            if (compare_en && dend_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event actual=(%0d,%0h) required=none", dend_addr, dend_charge);
                end else if (dend_addr !== exp_q[0].a || dend_charge !== exp_q[0].c) begin
                    failures++;
                    $display("FAIL event_data actual=(%0d,%0h) required=(%0d,%0h)",
                             dend_addr, dend_charge, exp_q[0].a, exp_q[0].c);
                end
                if (dend_rdy) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    ev_cnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n;
        reset = 1'b1; enable = 1'b1; clear_act = 1'b0; clear_config = 1'b0;
        config_addr = '0; config_value = '0; config_byte = '0; config_enable = 1'b0;
        next_step = 1'b0; syn_start = '0; syn_end = '0; syn_vld = 1'b0;
        for (int i = 0; i < 4096; i++) model_mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_syn_rdy", 32'(syn_rdy), 32'd0);
        chk("rst_dend_vld", 32'(dend_vld), 32'd0);
        chk("rst_dend_addr", 32'(dend_addr), 32'd0);
        chk("rst_dend_charge", 32'(dend_charge), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        compare_en = 1'b1;

        // Single-entry range and T+3 latency.
        cfg(10, 8'd5, 8'h7F);
        send_range(10, 10);
        @(negedge clk); chk("t1_vld_t1", 32'(dend_vld), 32'd0);
        @(negedge clk); chk("t1_vld_t2", 32'(dend_vld), 32'd0);
        @(negedge clk);
        chk("t1_vld_t3", 32'(dend_vld), 32'd1);
        chk("t1_addr", 32'(dend_addr), 32'd5);
        chk("t1_charge", 32'(dend_charge), 32'h7F);
        drain("t1_drain");
        chk("t1_step_done", 32'(step_done), 32'd1);

        // Wrapping range 4094..1.
        cfg(4094, 8'd20, 8'd1); cfg(4095, 8'd21, 8'd2);
        cfg(0, 8'd22, 8'd3);    cfg(1, 8'd23, 8'd4);
        base = ev_cnt;
        send_range(4094, 1);
        drain("t2_drain");
        chk("t2_count", 32'(ev_cnt - base), 32'd4);

        // Random backpressure over 0..15.
        for (int i = 0; i < 16; i++) cfg(i, 8'(40 + i), 8'(i + 1));
        rdy_mode = 2;
        base = ev_cnt;
        send_range(0, 15);
        drain("t3_drain");
        chk("t3_count", 32'(ev_cnt - base), 32'd16);
        rdy_mode = 1;

        // Zero-weight entries.
        cfg(2, 8'd70, 8'd5); cfg(3, 8'd71, 8'd0); cfg(4, 8'd72, 8'd6);
        cfg(5, 8'd73, 8'd0); cfg(6, 8'd74, 8'd7);
        base = ev_cnt;
        send_range(2, 6);
        drain("t4_drain");
        chk("t4_count", 32'(ev_cnt - base), SKIP ? 32'd3 : 32'd5);

        // Staging clear (byte 1) and an ignored code before the commit byte.
        @(posedge clk); #1;
        config_enable = 1'b1; config_addr = 12'd50; config_byte = 3'd2; config_value = 8'd9;
        @(posedge clk); #1; config_byte = 3'd1;
        @(posedge clk); #1; config_byte = 3'd5; config_value = 8'hAA;
        @(posedge clk); #1; config_byte = 3'd3; config_value = 8'd3;
        @(posedge clk); #1; config_enable = 1'b0; config_byte = 3'd0;
        model_mem[50] = 16'h0003;
        send_range(50, 50);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("stage_addr", 32'(dend_addr), 32'd0);
        chk("stage_charge", 32'(dend_charge), 32'd3);
        drain("stage_drain");

        @(posedge clk); #1; enable = 1'b0;
        @(negedge clk); chk("enable_low_rdy", 32'(syn_rdy), 32'd0);
        @(posedge clk); #1; enable = 1'b1;

        // clear_config mid-range.
        send_range(0, 15);
        repeat (4) @(posedge clk);
        #1; clear_config = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        n = 1;
        @(negedge clk); chk("t5_vld_drop", 32'(dend_vld), 32'd0);
        while (!clear_done && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_clear_cycles", 32'(n), 32'd4097);
        @(posedge clk); #1;
        chk("t5_done_held", 32'(clear_done), 32'd1);
        for (int i = 0; i < 4096; i++) model_mem[i] = 16'h0000;
        clear_config = 1'b0;
        @(posedge clk); #1;
        chk("t5_done_release", 32'(clear_done), 32'd0);
        base = ev_cnt;
        send_range(4094, 1);
        drain("t5_drain");
        chk("t5_count", 32'(ev_cnt - base), SKIP ? 32'd0 : 32'd4);

        // clear_act with two events queued under stall.
        cfg(30, 8'd60, 8'h11); cfg(31, 8'd61, 8'h22);
        cfg(32, 8'd62, 8'h33); cfg(33, 8'd63, 8'h44);
        rdy_mode = 0;
        @(posedge clk); @(posedge clk);
        send_range(30, 33);
        repeat (6) @(negedge clk);
        chk("t6_vld_stall", 32'(dend_vld), 32'd1);
        chk("t6_head_addr", 32'(dend_addr), 32'd60);
        @(posedge clk); #1; clear_act = 1'b1;
        @(posedge clk); #1; exp_q.delete();
        @(negedge clk);
        chk("t6_flushed", 32'(dend_vld), 32'd0);
        chk("t6_clear_done", 32'(clear_done), 32'd1);
        @(posedge clk); #1; clear_act = 1'b0;
        @(negedge clk);
        chk("t6_syn_rdy", 32'(syn_rdy), 32'd1);
        rdy_mode = 1;
        repeat (5) @(negedge clk);
        chk("t6_no_events", 32'(exp_q.size()), 32'd0);
        chk("t6_step_done", 32'(step_done), 32'd1);

        compare_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
